// File: rtl/countdown_pkg.sv
// countdown_pkg: shared definitions for the mm:ss countdown timer.
// Holds the FSM state codes (also used by display-side logic to decode
// actualState), the default prescaler division, the BCD time record and
// the helpers for preset validation and one-second decrement.
package countdown_pkg;

  localparam int TICK_DIV_DEFAULT = 100000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  // Field order matches the preset bus: {mDecimal, mUnit, sDecimal, sUnit}.
  typedef struct packed {
    logic [3:0] m_dec;
    logic [3:0] m_unit;
    logic [3:0] s_dec;
    logic [3:0] s_unit;
  } mmss_t;

  function automatic logic mmss_valid(mmss_t t);
    return (t.m_dec <= 4'd9) && (t.m_unit <= 4'd9) &&
           (t.s_dec <= 4'd5) && (t.s_unit <= 4'd9);
  endfunction

  // One-second decrement with BCD borrow chain. Callers never pass 00:00.
  function automatic mmss_t mmss_dec(mmss_t t);
    mmss_t r;
    r = t;
    if (t.s_unit != 4'd0) r.s_unit = t.s_unit - 4'd1;
    else begin
      r.s_unit = 4'd9;
      if (t.s_dec != 4'd0) r.s_dec = t.s_dec - 4'd1;
      else begin
        r.s_dec = 4'd5;
        if (t.m_unit != 4'd0) r.m_unit = t.m_unit - 4'd1;
        else begin
          r.m_unit = 4'd9;
          r.m_dec  = t.m_dec - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that produces a one-cycle tick every TICK_DIV
// enabled cycles.
//   clk_100MHz : clock
//   reset_n    : async active-low reset, clears the count
//   enable     : count this cycle
//   clear      : synchronous clear to 0 (wins over enable)
//   tick       : high in the enabled cycle where the count wraps
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss BCD countdown with load / start / pause strobes.
//   clk_100MHz  : clock
//   reset_n     : async active-low reset
//   load        : latch preset (ignored in RUN or if preset is not valid BCD time)
//   preset      : {mDecimal, mUnit, sDecimal, sUnit}
//   start       : begin (IDLE, non-zero) or resume (PAUSE)
//   pause       : freeze counting (RUN only)
//   mDecimal..sUnit : current digits
//   actualState : FSM state code
//   finish      : high only in DONE
// Same-cycle strobes resolve load > pause > start, skipping any that are
// illegal in the current state.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  mDecimal,
  output logic [3:0]  mUnit,
  output logic [3:0]  sDecimal,
  output logic [3:0]  sUnit,
  output logic [2:0]  actualState,
  output logic        finish
);

  state_t state;
  mmss_t  digits, dig_dec;
  logic   tick, run, load_ok, start_idle_ok;

  assign run     = (state == ST_RUN);
  assign dig_dec = mmss_dec(digits);

  always_comb begin
    load_ok       = 1'b0;
    start_idle_ok = 1'b0;
    if (load && mmss_valid(mmss_t'(preset)) &&
        (state == ST_IDLE || state == ST_PAUSE || state == ST_DONE))
      load_ok = 1'b1;
    // Starting at 00:00 would underflow on the first tick, so it is refused.
    if (state == ST_IDLE && start && !load_ok && digits != mmss_t'(16'h0))
      start_idle_ok = 1'b1;
  end

  // Fresh start counts a full second; resume from PAUSE keeps the partial count.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .enable     (run),
    .clear      (start_idle_ok),
    .tick       (tick)
  );

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      digits <= '0;
      finish <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_ok)            digits <= mmss_t'(preset);
          else if (start_idle_ok) state  <= ST_RUN;
        end
        ST_RUN: begin
          // A tick in the pause cycle still lands; reaching zero beats pause.
          if (tick) begin
            digits <= dig_dec;
            if (dig_dec == mmss_t'(16'h0)) begin
              state  <= ST_DONE;
              finish <= 1'b1;
            end else if (pause) state <= ST_PAUSE;
          end else if (pause) state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (load_ok) begin
            digits <= mmss_t'(preset);
            state  <= ST_IDLE;
          end else if (start) state <= ST_RUN;
        end
        ST_DONE: begin
          if (load_ok) begin
            digits <= mmss_t'(preset);
            state  <= ST_IDLE;
            finish <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          finish <= 1'b0;
        end
      endcase
    end
  end

  assign {mDecimal, mUnit, sDecimal, sUnit} = digits;
  assign actualState = state;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic        clk_100MHz = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [15:0] preset = 16'h0;
  logic [3:0]  mDecimal, mUnit, sDecimal, sUnit;
  logic [2:0]  actualState;
  logic        finish;

  int n_cmp = 0;
  int n_bad = 0;

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .load        (load),
    .preset      (preset),
    .start       (start),
    .pause       (pause),
    .mDecimal    (mDecimal),
    .mUnit       (mUnit),
    .sDecimal    (sDecimal),
    .sUnit       (sUnit),
    .actualState (actualState),
    .finish      (finish)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic        ld;
    logic [15:0] pre;
    logic        st;
    logic        pa;
    logic [15:0] dig;
    logic [2:0]  state;
    logic        fin;
  } vec_t;

  vec_t vt[25];

  function automatic logic [15:0] digs();
    return {mDecimal, mUnit, sDecimal, sUnit};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] d, input logic [2:0] s, input logic f);
    chk({name, ".digits"}, digs(), d);
    chk({name, ".state"}, {13'd0, actualState}, {13'd0, s});
    chk({name, ".finish"}, {15'd0, finish}, {15'd0, f});
  endtask

  // Advance n rising edges, ending 1 time unit after the last.
  task automatic step(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic strobe(input logic ld, input logic [15:0] pre, input logic st, input logic pa);
    load = ld; preset = pre; start = st; pause = pa;
    step(1);
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    // Each row is one cycle; expectations are the outputs after that edge.
    vt[0]  = '{1'b1, 16'h0A00, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0}; // bad mDec/mUnit
    vt[1]  = '{1'b1, 16'h0060, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0}; // sDec 6 bad
    vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0}; // start at 00:00
    vt[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0}; // pause in IDLE
    vt[4]  = '{1'b1, 16'h0959, 1'b0, 1'b0, 16'h0959, 3'd0, 1'b0};
    vt[5]  = '{1'b1, 16'h9959, 1'b0, 1'b0, 16'h9959, 3'd0, 1'b0}; // max
    vt[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9959, 3'd1, 1'b0}; // E0
    vt[7]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h9959, 3'd1, 1'b0}; // load in RUN
    vt[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h9959, 3'd1, 1'b0};
    vt[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h9959, 3'd2, 1'b0}; // prescaler=3
    vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9959, 3'd1, 1'b0}; // resume
    vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h9958, 3'd1, 1'b0}; // kept count
    vt[12] = '{1'b1, 16'h0001, 1'b1, 1'b1, 16'h9958, 3'd2, 1'b0}; // pause wins in RUN
    vt[13] = '{1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 3'd0, 1'b0}; // load wins in PAUSE
    vt[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 3'd0, 1'b0};
    vt[15] = '{1'b1, 16'h0070, 1'b0, 1'b0, 16'h0001, 3'd0, 1'b0};
    vt[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 3'd1, 1'b0};
    vt[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 3'd1, 1'b0};
    vt[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 3'd1, 1'b0};
    vt[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 3'd1, 1'b0};
    vt[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b1};
    vt[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd3, 1'b1};
    vt[22] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3'd3, 1'b1};
    vt[23] = '{1'b1, 16'h0A00, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b1};
    vt[24] = '{1'b1, 16'h0200, 1'b0, 1'b0, 16'h0200, 3'd0, 1'b0};

    // Reset state
    step(1);
    chk_all("rst_hold", 16'h0000, 3'd0, 1'b0);
    reset_n = 1'b1;
    step(3);
    chk_all("rst_idle", 16'h0000, 3'd0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      strobe(vt[i].ld, vt[i].pre, vt[i].st, vt[i].pa);
      chk_all($sformatf("vec%0d", i), vt[i].dig, vt[i].state, vt[i].fin);
    end

    // 01:05 countdown through minute borrow
    do_reset();
    strobe(1'b1, 16'h0105, 1'b0, 1'b0);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0);
    step(3);
    chk("t105_c3", digs(), 16'h0105);
    step(1);
    chk("t105_c4", digs(), 16'h0104);
    step(16);
    chk("t105_c20", digs(), 16'h0100);
    step(4);
    chk_all("t105_c24", 16'h0059, 3'd1, 1'b0);

    // 00:02 to DONE, then start ignored
    do_reset();
    strobe(1'b1, 16'h0002, 1'b0, 1'b0);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0);
    step(4);
    chk_all("t002_c4", 16'h0001, 3'd1, 1'b0);
    step(3);
    chk_all("t002_c7", 16'h0001, 3'd1, 1'b0);
    step(1);
    chk_all("t002_c8", 16'h0000, 3'd3, 1'b1);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0);
    step(8);
    chk_all("t002_restart", 16'h0000, 3'd3, 1'b1);

    // 10:00 with pause 2 cycles after start, resume, full borrow chain
    do_reset();
    strobe(1'b1, 16'h1000, 1'b0, 1'b0);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1);
    strobe(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_all("t1000_paused", 16'h1000, 3'd2, 1'b0);
    step(50);
    chk_all("t1000_hold", 16'h1000, 3'd2, 1'b0);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_all("t1000_resume", 16'h1000, 3'd1, 1'b0);
    step(1);
    chk("t1000_r1", digs(), 16'h1000);
    step(1);
    chk("t1000_r2", digs(), 16'h0959);

    // Async reset mid-RUN at 05:30
    do_reset();
    strobe(1'b1, 16'h0530, 1'b0, 1'b0);
    strobe(1'b0, 16'h0000, 1'b1, 1'b0);
    step(2);
    chk_all("t530_run", 16'h0530, 3'd1, 1'b0);
    reset_n = 1'b0;
    #2;
    chk_all("t530_async", 16'h0000, 3'd0, 1'b0);
    @(posedge clk_100MHz);
    #2;
    reset_n = 1'b1;
    step(10);
    chk_all("t530_stay_idle", 16'h0000, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
